// File: rtl/l2_response_engine.sv
// L2-side responder for L1 miss traffic: fixed-latency line-aligned acknowledgements,
// a one-entry evict buffer serialized against in-flight requests, and saturating statistics.
module l2_response_engine #(
  parameter int unsigned ADDRESS_WIDTH     = 32,
  parameter int unsigned BYTE_SELECT_WIDTH = 6,
  parameter int unsigned LATENCY           = 4,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_op,
  output logic [ADDRESS_WIDTH-1:0] rsp_addr,
  input  logic                     evict_in_valid,
  output logic                     evict_in_ready,
  input  logic [ADDRESS_WIDTH-1:0] evict_in_addr,
  output logic                     evict_out_valid,
  input  logic                     evict_out_ready,
  output logic [ADDRESS_WIDTH-1:0] evict_out_addr,
  input  logic                     clr_stats,
  output logic [CNT_WIDTH-1:0]     rd_cnt,
  output logic [CNT_WIDTH-1:0]     wr_cnt,
  output logic [CNT_WIDTH-1:0]     ev_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_EVICT
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_started;
  logic [7:0]               r_lat;
  logic [1:0]               r_op;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_ev_full;
  logic [ADDRESS_WIDTH-1:0] r_ev_addr;
  logic [CNT_WIDTH-1:0]     r_rd_cnt;
  logic [CNT_WIDTH-1:0]     r_wr_cnt;
  logic [CNT_WIDTH-1:0]     r_ev_cnt;

  logic                     w_req_ready;
  logic                     w_rsp_valid;
  logic                     w_ev_out_valid;
  logic                     w_req_fire;
  logic                     w_rsp_fire;
  logic                     w_ev_fire;
  logic                     w_ev_capture;
  logic                     w_rsp_is_rd;
  logic [ADDRESS_WIDTH-1:0] w_req_line;
  logic [ADDRESS_WIDTH-1:0] w_ev_line;

  assign w_req_line   = {req_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH], {BYTE_SELECT_WIDTH{1'b0}}};
  assign w_ev_line    = {evict_in_addr[ADDRESS_WIDTH-1:BYTE_SELECT_WIDTH], {BYTE_SELECT_WIDTH{1'b0}}};
  assign w_ev_capture = evict_in_valid && !r_ev_full;
  assign w_rsp_is_rd  = (r_op == 2'd0) || (r_op == 2'd3);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  // r_started keeps req_ready low for the first cycle after reset, so that
  // only evict_in_ready is high in that cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_req_ready    = 1'b0;
    w_rsp_valid    = 1'b0;
    w_ev_out_valid = 1'b0;
    w_req_fire     = 1'b0;
    w_rsp_fire     = 1'b0;
    w_ev_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ev_full) begin
          w_state_nxt = S_EVICT;
        end else begin
          w_req_ready = r_started;
          if (req_valid && r_started) begin
            w_req_fire  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_lat == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EVICT: begin
        w_ev_out_valid = 1'b1;
        if (evict_out_ready) begin
          w_ev_fire   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_lat     <= '0;
      r_op      <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if (w_req_fire) begin
        r_lat  <= 8'(LATENCY - 1);
        r_op   <= req_op;
        r_addr <= w_req_line;
      end else if (r_state == S_WAIT && r_lat != '0) begin
        r_lat <= r_lat - 8'd1;
      end
    end
  end

  // Capture and drain are mutually exclusive: capture needs an empty buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ev_full <= 1'b0;
      r_ev_addr <= '0;
    end else if (w_ev_fire) begin
      r_ev_full <= 1'b0;
    end else if (w_ev_capture) begin
      r_ev_full <= 1'b1;
      r_ev_addr <= w_ev_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
      r_ev_cnt <= '0;
    end else begin
      if (w_rsp_fire && w_rsp_is_rd)  r_rd_cnt <= sat_inc(r_rd_cnt);
      if (w_rsp_fire && !w_rsp_is_rd) r_wr_cnt <= sat_inc(r_wr_cnt);
      if (w_ev_fire)                  r_ev_cnt <= sat_inc(r_ev_cnt);
    end
  end

  assign req_ready       = w_req_ready;
  assign rsp_valid       = w_rsp_valid;
  assign rsp_op          = r_op;
  assign rsp_addr        = r_addr;
  assign evict_in_ready  = !r_ev_full;
  assign evict_out_valid = w_ev_out_valid;
  assign evict_out_addr  = r_ev_addr;
  assign rd_cnt          = r_rd_cnt;
  assign wr_cnt          = r_wr_cnt;
  assign ev_cnt          = r_ev_cnt;

endmodule

// File: tb/tb_l2_response_engine.sv
// Bench for l2_response_engine: table of single transactions, directed evict/reset/
// saturation sequences, and randomized traffic against a transaction-level model.
module tb_l2_response_engine;
  localparam int unsigned AW   = 32;
  localparam int unsigned BSW  = 6;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [1:0]    rsp_op;
  logic [AW-1:0] rsp_addr;
  logic          evict_in_valid = 1'b0, evict_in_ready;
  logic [AW-1:0] evict_in_addr = '0;
  logic          evict_out_valid, evict_out_ready = 1'b0;
  logic [AW-1:0] evict_out_addr;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] rd_cnt, wr_cnt, ev_cnt;

  l2_response_engine #(
    .ADDRESS_WIDTH(AW), .BYTE_SELECT_WIDTH(BSW), .LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_addr(rsp_addr),
    .evict_in_valid(evict_in_valid), .evict_in_ready(evict_in_ready), .evict_in_addr(evict_in_addr),
    .evict_out_valid(evict_out_valid), .evict_out_ready(evict_out_ready), .evict_out_addr(evict_out_addr),
    .clr_stats(clr_stats), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .ev_cnt(ev_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Transaction-level model: one outstanding request, a FIFO of buffered evicts.
  bit          mdl_on = 1'b0;
  bit          outst = 1'b0;
  int          acc = 0, since_rst = 0, run = 0;
  logic [1:0]  m_op = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] evq[$];
  int          m_rd = 0, m_wr = 0, m_ev = 0;
  bit          f_req = 1'b0, f_evin = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    int          hold;
    logic [31:0] e_addr;
    int          e_rd;
    int          e_wr;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~((32'd1 << BSW) - 32'd1);
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Called at a negedge with inputs set: checks outputs, advances the model, crosses one posedge.
  task automatic step();
    bit e_rr = 1'b0, e_rv = 1'b0, e_ev = 1'b0;
    bit rf, sf, ef, inf;
    if (mdl_on) begin
      run  = (evq.size() != 0 && !outst) ? run + 1 : 0;
      e_rr = (since_rst >= 1) && !outst && (evq.size() == 0);
      e_rv = outst && (cyc - acc >= int'(LAT));
      e_ev = (run >= 2);
      chk("req_ready", 32'(req_ready), 32'(e_rr));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("evict_out_valid", 32'(evict_out_valid), 32'(e_ev));
      chk("evict_in_ready", 32'(evict_in_ready), 32'(evq.size() == 0));
      if (e_rv) begin
        chk("rsp_op", 32'(rsp_op), 32'(m_op));
        chk("rsp_addr", rsp_addr, m_addr);
      end
      if (e_ev) chk("evict_out_addr", evict_out_addr, line_of(evq[0]));
      chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
      chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      chk("ev_cnt", 32'(ev_cnt), 32'(m_ev));
    end
    f_req  = 1'b0;
    f_evin = 1'b0;
    if (!rst_n) begin
      mdl_on = 1'b1; outst = 1'b0; evq.delete();
      m_rd = 0; m_wr = 0; m_ev = 0; since_rst = 0; run = 0;
    end else if (mdl_on) begin
      rf  = req_valid && e_rr;
      sf  = e_rv && rsp_ready;
      ef  = e_ev && evict_out_ready;
      inf = evict_in_valid && (evq.size() == 0);
      if (sf) begin
        outst = 1'b0;
        if (m_op == 2'd0 || m_op == 2'd3) m_rd = sat(m_rd);
        else                              m_wr = sat(m_wr);
      end
      if (rf) begin
        outst = 1'b1; m_op = req_op; m_addr = line_of(req_addr); acc = cyc + 1;
      end
      if (ef) begin
        void'(evq.pop_front());
        m_ev = sat(m_ev);
      end
      if (inf) evq.push_back(evict_in_addr);
      if (clr_stats) begin m_rd = 0; m_wr = 0; m_ev = 0; end
      since_rst++;
      f_req  = rf;
      f_evin = inf;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
    chk({tag, "_rsp_addr"}, rsp_addr, 32'd0);
    chk({tag, "_evict_out_valid"}, 32'(evict_out_valid), 32'd0);
    chk({tag, "_evict_out_addr"}, evict_out_addr, 32'd0);
    chk({tag, "_evict_in_ready"}, 32'(evict_in_ready), 32'd1);
    chk({tag, "_counters"}, {26'd0, rd_cnt, wr_cnt, ev_cnt}, 32'd0);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input int hold,
                        input bit clr_hs, output int lat, output logic [1:0] rop,
                        output logic [31:0] raddr);
    int n, t0;
    req_valid = 1'b1; req_op = op; req_addr = addr; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 64) begin step(); n++; end
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    step();
    t0 = cyc;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 300) begin step(); n++; end
    lat = cyc - t0; rop = rsp_op; raddr = rsp_addr;
    repeat (hold) step();
    rsp_ready = 1'b1; clr_stats = clr_hs;
    step();
    rsp_ready = 1'b0; clr_stats = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, n;
    logic [1:0]  rop;
    logic [31:0] raddr;
    bit          saw;

    tbl[0] = '{2'd0, 32'h1234_5678, 5, 32'h1234_5640, 1, 0};
    tbl[1] = '{2'd1, 32'h0000_003F, 0, 32'h0000_0000, 1, 1};
    tbl[2] = '{2'd3, 32'hFFFF_FFFF, 2, 32'hFFFF_FFC0, 2, 1};
    tbl[3] = '{2'd2, 32'h8000_0040, 0, 32'h8000_0040, 2, 2};
    tbl[4] = '{2'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEC0, 3, 2};
    tbl[5] = '{2'd3, 32'h0000_0001, 0, 32'h0000_0000, 3, 2};
    tbl[6] = '{2'd2, 32'h1111_1180, 3, 32'h1111_1180, 3, 3};
    tbl[7] = '{2'd1, 32'h7FFF_FFBF, 0, 32'h7FFF_FF80, 3, 3};

    @(negedge clk);
    rst_n = 1'b0;
    step();
    reset_check("reset");
    step();
    rst_n = 1'b1;

    // Table of single transactions, counters saturating at 3.
    for (int i = 0; i < 8; i++) begin
      do_req(tbl[i].op, tbl[i].addr, tbl[i].hold, 1'b0, lat, rop, raddr);
      chk("tbl_latency", 32'(lat), 32'(LAT));
      chk("tbl_rsp_op", 32'(rop), 32'(tbl[i].op));
      chk("tbl_rsp_addr", raddr, tbl[i].e_addr);
      chk("tbl_rd_cnt", 32'(rd_cnt), 32'(tbl[i].e_rd));
      chk("tbl_wr_cnt", 32'(wr_cnt), 32'(tbl[i].e_wr));
      chk("tbl_req_ready_after_rsp", 32'(req_ready), 32'd1);
    end

    // Buffered evict goes out before a waiting request.
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    evict_in_valid = 1'b1; evict_in_addr = 32'hABCD_00FF; step(); evict_in_valid = 1'b0;
    req_valid = 1'b1; req_op = 2'd3; req_addr = 32'h0000_1000;
    chk("evfirst_req_ready", 32'(req_ready), 32'd0);
    n = 0;
    while (!evict_out_valid && n < 16) begin step(); n++; end
    chk("evfirst_evict_valid", 32'(evict_out_valid), 32'd1);
    chk("evfirst_evict_addr", evict_out_addr, 32'hABCD_00C0);
    chk("evfirst_req_blocked", 32'(req_ready), 32'd0);
    evict_out_ready = 1'b1; step(); evict_out_ready = 1'b0;
    chk("evfirst_ev_cnt", 32'(ev_cnt), 32'd1);
    chk("evfirst_req_ready_after", 32'(req_ready), 32'd1);
    do_req(2'd3, 32'h0000_1000, 0, 1'b0, lat, rop, raddr);
    chk("evfirst_req_latency", 32'(lat), 32'(LAT));
    chk("evfirst_rd_cnt", 32'(rd_cnt), 32'd1);

    // Evict arriving during a write-back's wait is held until the response completes.
    clr_stats = 1'b1; step(); clr_stats = 1'b0;
    req_valid = 1'b1; req_op = 2'd1; req_addr = 32'h0000_2A7C;
    n = 0;
    while (!req_ready && n < 16) begin step(); n++; end
    step(); req_valid = 1'b0;
    evict_in_valid = 1'b1; evict_in_addr = 32'h5555_AAAA; step(); evict_in_valid = 1'b0;
    evict_out_ready = 1'b1;
    saw = 1'b0; n = 0;
    while (!rsp_valid && n < 16) begin saw |= evict_out_valid; step(); n++; end
    saw |= evict_out_valid;
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0; evict_out_ready = 1'b0;
    chk("wb_evict_held", 32'(saw), 32'd0);
    chk("wb_wr_cnt", 32'(wr_cnt), 32'd1);
    n = 0;
    while (!evict_out_valid && n < 16) begin step(); n++; end
    chk("wb_evict_valid", 32'(evict_out_valid), 32'd1);
    chk("wb_evict_addr", evict_out_addr, 32'h5555_AA80);
    evict_out_ready = 1'b1; step(); evict_out_ready = 1'b0;
    chk("wb_ev_cnt", 32'(ev_cnt), 32'd1);
    chk("wb_wr_cnt_after", 32'(wr_cnt), 32'd1);

    // Reset during WAIT with the evict buffer full drops both.
    req_valid = 1'b1; req_op = 2'd0; req_addr = 32'h0000_3003;
    n = 0;
    while (!req_ready && n < 16) begin step(); n++; end
    step(); req_valid = 1'b0;
    evict_in_valid = 1'b1; evict_in_addr = 32'h0BAD_0BAD; step(); evict_in_valid = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    reset_check("midreset");
    rsp_ready = 1'b1; evict_out_ready = 1'b1; saw = 1'b0;
    repeat (20) begin saw |= rsp_valid | evict_out_valid; step(); end
    rsp_ready = 1'b0; evict_out_ready = 1'b0;
    chk("midreset_quiet", 32'(saw), 32'd0);
    chk("midreset_counters", {26'd0, rd_cnt, wr_cnt, ev_cnt}, 32'd0);

    // Saturation at 3, then clear beating a same-cycle increment.
    for (int i = 0; i < 5; i++) do_req(2'd0, 32'h0000_4000 + 32'(i * 64), 0, 1'b0, lat, rop, raddr);
    chk("sat_rd_cnt", 32'(rd_cnt), 32'(CMAX));
    do_req(2'd0, 32'h0000_5000, 0, 1'b1, lat, rop, raddr);
    chk("clr_wins_rd_cnt", 32'(rd_cnt), 32'd0);

    // Randomized traffic; the model in step() checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      if (!req_valid || f_req) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_op    = 2'($urandom);
        req_addr  = $urandom;
      end
      if (!evict_in_valid || f_evin) begin
        evict_in_valid = ($urandom_range(0, 7) == 0);
        evict_in_addr  = $urandom;
      end
      rsp_ready       = ($urandom_range(0, 1) == 1);
      evict_out_ready = ($urandom_range(0, 2) != 0);
      clr_stats       = ($urandom_range(0, 49) == 0);
      step();
    end
    req_valid = 1'b0; evict_in_valid = 1'b0; clr_stats = 1'b0;
    rsp_ready = 1'b1; evict_out_ready = 1'b1;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
